frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// APU frame sequencer: divides CPU cycles into quarter/half-frame clocks and raises the frame IRQ.
// NTSC step timing by default; define FRAME_SEQ_PAL_EN for PAL step and period values.
module frame_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_ce,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_clr,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] seq_step
);

`ifdef FRAME_SEQ_PAL_EN
  localparam logic [15:0] STEP_0   = 16'd8313;
  localparam logic [15:0] STEP_1   = 16'd16627;
  localparam logic [15:0] STEP_2   = 16'd24939;
  localparam logic [15:0] STEP_3   = 16'd33252;
  localparam logic [15:0] STEP_4   = 16'd41565;
  localparam logic [15:0] PERIOD_4 = 16'd33253;
  localparam logic [15:0] PERIOD_5 = 16'd41566;
`else
  localparam logic [15:0] STEP_0   = 16'd7457;
  localparam logic [15:0] STEP_1   = 16'd14913;
  localparam logic [15:0] STEP_2   = 16'd22371;
  localparam logic [15:0] STEP_3   = 16'd29829;
  localparam logic [15:0] STEP_4   = 16'd37281;
  localparam logic [15:0] PERIOD_4 = 16'd29830;
  localparam logic [15:0] PERIOD_5 = 16'd37282;
`endif

  typedef enum logic {
    MODE_FOUR = 1'b0,
    MODE_FIVE = 1'b1
  } mode_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
    logic       q;
    logic       h;
    logic       irq;
  } step_t;

  mode_t       mode;
  logic        inhibit;
  logic [15:0] cycle_cnt;
  logic [15:0] next_cnt;
  step_t       step;
  logic        wrap;
  logic        irq_set;
  logic        irq_clear;
  logic        unused_data;

  assign next_cnt    = cycle_cnt + 16'd1;
  assign wrap        = next_cnt == ((mode == MODE_FIVE) ? PERIOD_5 : PERIOD_4);
  assign unused_data = ^wr_data[5:0];

  always_comb begin
    // NOTE: defaulting the whole struct first keeps this purely combinational; no latch on a miss.
    step = '0;
    if (next_cnt == STEP_0) begin
      step.hit = 1'b1;
      step.idx = 3'd0;
      step.q   = 1'b1;
    end else if (next_cnt == STEP_1) begin
      step.hit = 1'b1;
      step.idx = 3'd1;
      step.q   = 1'b1;
      step.h   = 1'b1;
    end else if (next_cnt == STEP_2) begin
      step.hit = 1'b1;
      step.idx = 3'd2;
      step.q   = 1'b1;
    end else if (next_cnt == STEP_3) begin
      // In five-step mode this step is reached but clocks nothing.
      step.hit = 1'b1;
      step.idx = 3'd3;
      step.q   = (mode == MODE_FOUR);
      step.h   = (mode == MODE_FOUR);
      step.irq = (mode == MODE_FOUR);
    end else if (mode == MODE_FIVE && next_cnt == STEP_4) begin
      step.hit = 1'b1;
      step.idx = 3'd4;
      step.q   = 1'b1;
      step.h   = 1'b1;
    end
  end

  // A write on the same clock suppresses the step, so it cannot raise the IRQ either.
  assign irq_set   = cpu_ce & ~wr_en & step.irq & ~inhibit;
  assign irq_clear = irq_clr | (wr_en & wr_data[6]);

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments; reset is sampled on the clock edge only.
    if (!rst_n) begin
      mode          <= MODE_FOUR;
      inhibit       <= 1'b0;
      cycle_cnt     <= '0;
      seq_step      <= '0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_irq     <= 1'b0;
    end else begin
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      if (wr_en) begin
        mode          <= mode_t'(wr_data[7]);
        inhibit       <= wr_data[6];
        cycle_cnt     <= '0;
        seq_step      <= '0;
        quarter_frame <= wr_data[7];
        half_frame    <= wr_data[7];
      end else if (cpu_ce) begin
        cycle_cnt <= wrap ? '0 : next_cnt;
        if (step.hit) begin
          seq_step      <= step.idx;
          quarter_frame <= step.q;
          half_frame    <= step.h;
        end
        if (wrap) begin
          seq_step <= '0;
        end
      end
      frame_irq <= irq_set | (frame_irq & ~irq_clear);
    end
  end

endmodule
